// File: rtl/rtc_mini_core_if.sv
// rtl/rtc_mini_core_if.sv - command word in, time accumulator views out
interface rtc_mini_core_if;
    logic [71:0] time_reg_ns_in;
    logic [71:0] time_reg_ns;
    logic [63:0] time_ptp_ns;
    logic [63:0] sync_time_ptp_ns;

    modport master (
        output time_reg_ns_in,
        input  time_reg_ns,
        input  time_ptp_ns,
        input  sync_time_ptp_ns
    );

    modport slave (
        input  time_reg_ns_in,
        output time_reg_ns,
        output time_ptp_ns,
        output sync_time_ptp_ns
    );
endinterface

// File: rtl/rtc_mini_core.sv
// rtl/rtc_mini_core.sv - free-running ns time accumulator with edge-triggered SET/OFFSET/RATE commands
module rtc_mini_core #(
    parameter logic [15:0] DEFAULT_INC = 16'h0800
) (
    input  logic            clk,
    input  logic            rst,
    rtc_mini_core_if.slave  bus
);

    localparam logic [7:0] CMD_SET    = 8'h01;
    localparam logic [7:0] CMD_OFFSET = 8'h02;
    localparam logic [7:0] CMD_RATE   = 8'h03;

    logic [71:0] acc_q, acc_d;
    logic [15:0] inc_q, inc_d;
    logic [71:0] prev_in_q, prev_in_d;
    logic [63:0] sync_q, sync_d;

    logic [7:0]  cmd;
    logic [63:0] operand;
    logic [71:0] acc_inc;
    logic        exec;

    always_comb begin
        cmd       = bus.time_reg_ns_in[71:64];
        operand   = bus.time_reg_ns_in[63:0];
        acc_inc   = acc_q + {56'b0, inc_q};
        acc_d     = acc_inc;
        inc_d     = inc_q;
        prev_in_d = bus.time_reg_ns_in;
        sync_d    = acc_q[71:8];
        exec      = 1'b0;

        // Only a changed, non-idle word executes, so a held command fires once;
        // an unknown compare resolves false and never fires.
        if ((bus.time_reg_ns_in != prev_in_q) && (cmd != 8'h00)) begin
            exec = 1'b1;
        end

        if (exec) begin
            case (cmd)
                CMD_SET:    acc_d = {operand, 8'h00};
                // Signed operand: the 72-bit add wraps, giving two's-complement subtraction.
                CMD_OFFSET: acc_d = acc_inc + {operand, 8'h00};
                CMD_RATE: begin
                    if (operand[15:0] != 16'h0000) begin
                        inc_d = operand[15:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q     <= 72'd0;
            inc_q     <= DEFAULT_INC;
            prev_in_q <= 72'd0;
            sync_q    <= 64'd0;
        end else begin
            acc_q     <= acc_d;
            inc_q     <= inc_d;
            prev_in_q <= prev_in_d;
            sync_q    <= sync_d;
        end
    end

    assign bus.time_reg_ns      = acc_q;
    assign bus.time_ptp_ns      = acc_q[71:8];
    assign bus.sync_time_ptp_ns = sync_q;

endmodule

// File: tb/tb_rtc_mini_core.sv
// tb/tb_rtc_mini_core.sv - directed vector bench for rtc_mini_core
module tb_rtc_mini_core;

    logic clk;
    logic rst;

    rtc_mini_core_if bus ();

    rtc_mini_core #(.DEFAULT_INC(16'h0800)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    typedef struct {
        logic [71:0] word;
        int          n_edges;
        logic [63:0] exp_ptp;
        logic [63:0] exp_sync;
        logic [7:0]  exp_frac;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string name, input logic [63:0] ptp,
                                 input logic [63:0] sync, input logic [7:0] frac);
        check({name, ".reg"},  bus.time_reg_ns, {ptp, frac});
        check({name, ".ptp"},  {8'h00, bus.time_ptp_ns}, {8'h00, ptp});
        check({name, ".sync"}, {8'h00, bus.sync_time_ptp_ns}, {8'h00, sync});
    endtask

    function automatic logic [71:0] w(input logic [7:0] c, input logic [63:0] op);
        return {c, op};
    endfunction

    initial begin
        logic [63:0] neg500;
        logic [63:0] near_top;
        neg500   = 64'd0 - 64'd500;
        near_top = 64'hFFFF_FFFF_FFFF_FFFC;

        vecs.push_back('{w(8'h00, 64'd0),         1,  64'd8,       64'd0,       8'h00, "first_edge"});
        vecs.push_back('{w(8'h00, 64'd0),         99, 64'd800,     64'd792,     8'h00, "free_run"});
        vecs.push_back('{w(8'h01, 64'd1000000),   1,  64'd1000000, 64'd800,     8'h00, "set"});
        vecs.push_back('{w(8'h01, 64'd1000000),   1,  64'd1000008, 64'd1000000, 8'h00, "set_hold1"});
        vecs.push_back('{w(8'h01, 64'd1000000),   9,  64'd1000080, 64'd1000072, 8'h00, "set_hold10"});
        vecs.push_back('{w(8'h00, 64'd0),         1,  64'd1000088, 64'd1000080, 8'h00, "idle_a"});
        vecs.push_back('{w(8'h01, 64'd992),       1,  64'd992,     64'd1000088, 8'h00, "set992"});
        vecs.push_back('{w(8'h00, 64'd0),         1,  64'd1000,    64'd992,     8'h00, "idle_b"});
        vecs.push_back('{w(8'h02, neg500),        1,  64'd508,     64'd1000,    8'h00, "offset_neg"});
        vecs.push_back('{w(8'h00, 64'd0),         1,  64'd516,     64'd508,     8'h00, "idle_c"});
        vecs.push_back('{w(8'h01, 64'd992),       1,  64'd992,     64'd516,     8'h00, "set992_b"});
        vecs.push_back('{w(8'h00, 64'd0),         1,  64'd1000,    64'd992,     8'h00, "idle_d"});
        vecs.push_back('{w(8'h02, 64'd500),       1,  64'd1508,    64'd1000,    8'h00, "offset_pos"});
        vecs.push_back('{w(8'h00, 64'd0),         1,  64'd1516,    64'd1508,    8'h00, "idle_e"});
        vecs.push_back('{w(8'h03, 64'h880),       1,  64'd1524,    64'd1516,    8'h00, "rate_old_inc"});
        vecs.push_back('{w(8'h00, 64'd0),         1,  64'd1532,    64'd1524,    8'h80, "rate_half"});
        vecs.push_back('{w(8'h00, 64'd0),         1,  64'd1541,    64'd1532,    8'h00, "rate_17ns"});
        vecs.push_back('{w(8'h03, 64'd0),         1,  64'd1549,    64'd1541,    8'h80, "rate_zero"});
        vecs.push_back('{w(8'h00, 64'd0),         1,  64'd1558,    64'd1549,    8'h00, "rate_kept"});
        vecs.push_back('{w(8'h03, 64'h800),       1,  64'd1566,    64'd1558,    8'h80, "rate_back"});
        vecs.push_back('{w(8'h00, 64'd0),         1,  64'd1574,    64'd1566,    8'h80, "rate_8ns"});
        vecs.push_back('{w(8'h01, near_top),      1,  near_top,    64'd1574,    8'h00, "set_top"});
        vecs.push_back('{w(8'h00, 64'd0),         1,  64'd4,       near_top,    8'h00, "wrap"});
        vecs.push_back('{w(8'h07, 64'd5),         1,  64'd12,      64'd4,       8'h00, "bad_cmd"});
        vecs.push_back('{w(8'h00, 64'd123),       1,  64'd20,      64'd12,      8'h00, "cmd0_change"});

        rst = 1'b0;
        bus.time_reg_ns_in = w(8'h01, 64'd777);
        repeat (3) @(negedge clk);
        check_outputs("reset_hold", 64'd0, 64'd0, 8'h00);

        bus.time_reg_ns_in = 72'd0;
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            bus.time_reg_ns_in = vecs[i].word;
            repeat (vecs[i].n_edges) @(posedge clk);
            @(negedge clk);
            check_outputs(vecs[i].name, vecs[i].exp_ptp, vecs[i].exp_sync, vecs[i].exp_frac);
        end

        // Asynchronous reset between edges, then a command waiting at release.
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_outputs("async_reset", 64'd0, 64'd0, 8'h00);
        @(negedge clk);
        bus.time_reg_ns_in = w(8'h01, 64'd5000);
        @(negedge clk);
        check_outputs("reset_with_cmd", 64'd0, 64'd0, 8'h00);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_outputs("cmd_at_release", 64'd5000, 64'd0, 8'h00);
        @(posedge clk);
        @(negedge clk);
        check_outputs("after_release", 64'd5008, 64'd5000, 8'h00);

        // A word present at release equal to the reset value of PREV_IN must not fire.
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        bus.time_reg_ns_in = 72'd0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_outputs("release_idle", 64'd8, 64'd0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rtc_mini_core.md
RTC_MINI_CORE -- requirements
Module: rtc_mini

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  RTC clock, 125 MHz nominal (8 ns period); all logic on rising edge.
REQ-003 rst  input  1  asynchronous active-low reset: rst=0 resets all state immediately, release is synchronous to clk.
REQ-004 time_reg_ns_in  input  72  command word: [71:64] cmd, [63:0] operand.
REQ-005 time_reg_ns  output  72  full time accumulator: [71:8] integer ns, [7:0] fractional ns (1/256 ns units).
REQ-006 time_ptp_ns  output  64  current integer ns, equal to time_reg_ns[71:8].
REQ-007 sync_time_ptp_ns  output  64  time_ptp_ns delayed one clk, registered, for consumers in other timing paths.
REQ-008 Parameter DEFAULT_INC, default 16'h0800 (8.0 ns), meaning: per-cycle increment loaded at reset, in 1/256 ns.

Function
REQ-009 Internal state: 72-bit accumulator ACC, 16-bit increment INC, 72-bit register PREV_IN holding the previous cycle's time_reg_ns_in.
REQ-010 Every clk without an executing command: ACC <= ACC + {56'b0, INC}, modulo 2^72 (wrap silently to 0).
REQ-011 A command SHALL execute in a cycle only when time_reg_ns_in != PREV_IN and cmd != 8'h00 (edge-detected; a held word executes once).
REQ-012 cmd 8'h01 SET: ACC <= {operand, 8'h00}; no increment that cycle.
REQ-013 cmd 8'h02 OFFSET: ACC <= ACC + {operand, 8'h00} + INC, operand two's-complement signed, result modulo 2^72.
REQ-014 cmd 8'h03 RATE: INC <= operand[15:0] if nonzero (zero ignored, INC unchanged); ACC increments with the old INC that cycle.
REQ-015 Any other cmd value SHALL be ignored (normal increment).
REQ-016 To repeat an identical command, the driver changes the word in between (e.g. through cmd 8'h00); this is the documented usage.
REQ-017 PREV_IN <= time_reg_ns_in every cycle; an X/unknown input SHALL NOT be treated as a command (simulation: compare with !==-free logic; synthesis naturally).
REQ-018 time_reg_ns and time_ptp_ns SHALL be driven directly from ACC (zero latency from ACC update); sync_time_ptp_ns SHALL lag time_ptp_ns by exactly one clk.
REQ-019 Outputs SHALL be glitch-free registered values; no combinational path from time_reg_ns_in to any output.

Reset
REQ-020 While rst=0: ACC=0, INC=DEFAULT_INC, PREV_IN=0, sync_time_ptp_ns=0; hence time_reg_ns=0, time_ptp_ns=0.
REQ-021 Reset asserted mid-operation SHALL clear all state asynchronously regardless of clk; a command present at release executes on the first edge only if it differs from 0 (PREV_IN reset value).
REQ-022 The first rising edge after release SHALL produce time_ptp_ns=8 with DEFAULT_INC.

Verification
REQ-023 Free run: release rst, cmd=0, 100 edges -> time_ptp_ns=800, sync_time_ptp_ns=792, time_reg_ns[7:0]=0.
REQ-024 SET: apply {8'h01, 64'd1_000_000} for one cycle -> time_ptp_ns=1_000_000 that edge, 1_000_008 next edge; holding the word 10 cycles executes once (ACC advances 8 ns per cycle after).
REQ-025 OFFSET: at time_ptp_ns=1000 apply {8'h02, -64'd500} -> next value 508; with +500 -> 1508.
REQ-026 RATE: apply {8'h03, 64'h0000_0000_0000_0880} (8.5 ns) -> after 2 further edges ACC advances 17 ns exactly, fraction returns to 0; operand 0 -> rate unchanged.
REQ-027 Wrap: SET 64'hFFFF_FFFF_FFFF_FFFC -> next edge time_ptp_ns=4 (wrap through zero).
REQ-028 Async reset: drop rst between clk edges while running -> all outputs 0 immediately, before the next edge.
